// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU matrix datapath: element/matrix geometry,
// the flattened matrix type, the loader state encoding and an index helper.
package mpu_pkg;

    localparam int ELEM_W   = 8;
    localparam int DIM      = 5;
    localparam int N        = DIM * DIM;
    localparam int MATRIX_W = ELEM_W * N;

    // Flattened matrix, element k at [ELEM_W*k +: ELEM_W]
    typedef logic signed [MATRIX_W-1:0] matrix_t;

    // Single signed element as carried on the input stream
    typedef logic signed [ELEM_W-1:0] elem_t;

    // Loader control states: FILL collects elements, HOLD parks a finished
    // matrix until the output slot frees up
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit offset of element (col,row) inside a flattened matrix;
    // arrival index is k = row + DIM*col
    function automatic int at(input int col, input int row);
        return ELEM_W * (row + DIM * col);
    endfunction

endpackage

// File: rtl/mpu_matrix_loader.sv
// Matrix loader: gathers DIM*DIM signed elements from a valid/ready stream
// into an assembly buffer and hands complete matrices to a registered
// valid/ready output slot. The next matrix may assemble while the downstream
// still holds the current one; a finished matrix that finds the slot busy is
// parked (HOLD) and the input is stalled until the slot frees.
module mpu_matrix_loader #(
    parameter int DIM    = mpu_pkg::DIM,
    parameter int ELEM_W = mpu_pkg::ELEM_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ELEM_W-1:0]           in_data,
    input  logic                        in_last,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ELEM_W*DIM*DIM-1:0]   out_matrix,
    output logic [4:0]                  fill_count,
    output logic                        frame_err
);

    import mpu_pkg::*;

    localparam int N  = DIM * DIM;
    localparam int MW = ELEM_W * N;

    // Index of the final element of a matrix; also the stash slot used in HOLD
    localparam logic [4:0] LAST_IDX = 5'(N - 1);

    // Control state
    state_t     state;
    state_t     state_next;
    logic [4:0] count_next;

    // Assembly buffer: slots 0..N-2 collect the matrix, slot N-1 holds the
    // final element while a finished matrix waits in HOLD
    logic signed [MW-1:0] assembly;

    // Handshake terms
    logic accept;
    logic consume;
    logic slot_free;

    // Decoded per-cycle actions from the FSM
    logic asm_wr;       // write in_data at assembly[fill_count]
    logic asm_clr;      // discard partial assembly
    logic load_direct;  // final element goes straight into the output slot
    logic load_stash;   // parked matrix moves into the output slot
    logic err_set;      // framing violation seen this cycle

    // Input is taken only while collecting and never in the reset cycle
    assign in_ready  = !reset && (state == FILL);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign slot_free = !out_valid || consume;

    // State and fill counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            fill_count <= '0;
        end else begin
            state      <= state_next;
            fill_count <= count_next;
        end
    end

    // Next-state, counter and datapath-action decode
    always_comb begin
        state_next  = state;
        count_next  = fill_count;
        asm_wr      = 1'b0;
        asm_clr     = 1'b0;
        load_direct = 1'b0;
        load_stash  = 1'b0;
        err_set     = 1'b0;

        case (state)
            FILL: begin
                if (flush) begin
                    // Flush wins over a same-cycle accept; the element is dropped
                    count_next = '0;
                    asm_clr    = 1'b1;
                end else if (accept) begin
                    if (fill_count == LAST_IDX) begin
                        // Matrix completes regardless of in_last; a missing
                        // in_last is only flagged
                        err_set = !in_last;
                        if (slot_free) begin
                            load_direct = 1'b1;
                            count_next  = '0;
                        end else begin
                            // Park the last element in the stash slot and stall
                            asm_wr     = 1'b1;
                            state_next = HOLD;
                        end
                    end else if (in_last) begin
                        // Early in_last: drop this element and the partial matrix
                        err_set    = 1'b1;
                        asm_clr    = 1'b1;
                        count_next = '0;
                    end else begin
                        asm_wr     = 1'b1;
                        count_next = fill_count + 5'd1;
                    end
                end
            end

            HOLD: begin
                if (flush) begin
                    // The parked matrix counts as partial assembly and is lost
                    asm_clr    = 1'b1;
                    count_next = '0;
                    state_next = FILL;
                end else if (slot_free) begin
                    load_stash = 1'b1;
                    count_next = '0;
                    state_next = FILL;
                end
            end

            default: begin
                state_next = FILL;
                count_next = '0;
            end
        endcase
    end

    // Assembly buffer: element writes and discards
    always_ff @(posedge clk) begin
        if (reset) begin
            assembly <= '0;
        end else if (asm_clr) begin
            assembly <= '0;
        end else if (asm_wr) begin
            assembly[ELEM_W*fill_count +: ELEM_W] <= in_data;
        end
    end

    // Output slot data: only changes on a load edge, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            out_matrix <= '0;
        end else if (load_direct) begin
            out_matrix <= {in_data, assembly[MW-ELEM_W-1:0]};
        end else if (load_stash) begin
            out_matrix <= assembly;
        end
    end

    // Output slot valid: a load keeps/sets it, a consume without load clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (load_direct || load_stash) begin
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky framing error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (err_set) begin
            frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader. Expected matrices come from a
// plain packing model: element k of a frame sits at bits [8*k +: 8].
`timescale 1ns/1ps
module tb_mpu_matrix_loader;

    localparam int N  = 25;
    localparam int EW = 8;
    localparam int MW = EW * N;

    typedef logic [EW-1:0] frame_t [N];

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_data;
    logic          in_last;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_matrix;
    logic [4:0]    fill_count;
    logic          frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mpu_matrix_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_matrix (out_matrix),
        .fill_count (fill_count),
        .frame_err  (frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] pack(input frame_t f);
        logic [MW-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) m[EW*k +: EW] = f[k];
        return m;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < N; k++) f[k] = EW'($urandom_range(0, 255));
        return f;
    endfunction

    // Present one element and hold it until accepted (bounded wait)
    task automatic send(input logic [EW-1:0] d, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #0;
        while (!in_ready && waited < 64) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input logic last_ok);
        for (int k = 0; k < N; k++) send(f[k], (k == N - 1) ? last_ok : 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL reset_fill_count: got %0d required 0", fill_count); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b required 0", frame_err); end
        n_checks++; if (out_matrix !== '0) begin n_fail++; $display("FAIL reset_out_matrix: got %h required 0", out_matrix); end
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_single_stream();
        frame_t f;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) f[k] = EW'(k);
        for (int k = 0; k < N - 1; k++) send(f[k], 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %0b required 0", out_valid); end
        n_checks++; if (fill_count !== 5'd24) begin n_fail++; $display("FAIL stream_fill_24: got %0d required 24", fill_count); end
        send(f[N-1], 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_matrix !== pack(f)) begin n_fail++; $display("FAIL stream_matrix: got %h required %h", out_matrix, pack(f)); end
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL stream_fill_0: got %0d required 0", fill_count); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL stream_frame_err: got %0b required 0", frame_err); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_consumed: got %0b required 0", out_valid); end
        n_checks++; if (out_matrix !== pack(f)) begin n_fail++; $display("FAIL stream_retain: got %h required %h", out_matrix, pack(f)); end
    endtask

    task automatic test_hold_stall();
        frame_t a, b;
        a = rand_frame();
        b = rand_frame();
        out_ready = 1'b0;
        send_frame(a, 1'b1);
        n_checks++; if (out_matrix !== pack(a)) begin n_fail++; $display("FAIL hold_first: got %h required %h", out_matrix, pack(a)); end
        send_frame(b, 1'b1);
        in_valid = 1'b1; in_data = 8'hA5;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %0b required 0", in_ready); end
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_matrix !== pack(a)) begin n_fail++; $display("FAIL hold_stable: got %h required %h", out_matrix, pack(a)); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %0b required 1", out_valid); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_matrix !== pack(b)) begin n_fail++; $display("FAIL hold_release_matrix: got %h required %h", out_matrix, pack(b)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %0b required 1", in_ready); end
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL hold_release_fill: got %0d required 0", fill_count); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_no_bubble();
        frame_t a, b;
        a = rand_frame();
        b = rand_frame();
        out_ready = 1'b0;
        send_frame(a, 1'b1);
        for (int k = 0; k < N - 1; k++) send(b[k], 1'b0);
        out_ready = 1'b1;
        send(b[N-1], 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nobubble_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_matrix !== pack(b)) begin n_fail++; $display("FAIL nobubble_matrix: got %h required %h", out_matrix, pack(b)); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobubble_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_continuous();
        frame_t        fr [3];
        logic [MW-1:0] expq [$];
        logic [MW-1:0] exp_m;
        int            got;
        got = 0;
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fr[f] = rand_frame();
            if (f == 0) begin
                fr[f][0] = 8'h80; fr[f][1] = 8'h7F; fr[f][2] = 8'hFF; fr[f][3] = 8'h01;
            end
            expq.push_back(pack(fr[f]));
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                send(fr[f][k], k == N - 1);
                n_checks++;
                if (out_valid !== (k == N - 1)) begin
                    n_fail++;
                    $display("FAIL cont_valid f%0d k%0d: got %0b required %0b", f, k, out_valid, (k == N - 1));
                end
                if (out_valid === 1'b1 && expq.size() > 0) begin
                    exp_m = expq.pop_front();
                    got++;
                    n_checks++;
                    if (out_matrix !== exp_m) begin
                        n_fail++;
                        $display("FAIL cont_matrix f%0d: got %h required %h", f, out_matrix, exp_m);
                    end
                end
            end
        end
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL cont_count: got %0d required 3", got); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_frame_err();
        frame_t c;
        c = rand_frame();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) send(EW'($urandom_range(0, 255)), 1'b0);
        send(8'h3C, 1'b1);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %0b required 1", frame_err); end
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL ferr_fill: got %0d required 0", fill_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_no_output: got %0b required 0", out_valid); end
        send_frame(c, 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_matrix !== pack(c)) begin n_fail++; $display("FAIL ferr_next_matrix: got %h required %h", out_matrix, pack(c)); end
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %0b required 1", frame_err); end
        tick();
    endtask

    task automatic test_flush();
        frame_t p, q;
        p = rand_frame();
        q = rand_frame();
        out_ready = 1'b0;
        send_frame(p, 1'b1);
        for (int k = 0; k < 12; k++) send(EW'($urandom_range(0, 255)), 1'b0);
        n_checks++; if (fill_count !== 5'd12) begin n_fail++; $display("FAIL flush_pre_fill: got %0d required 12", fill_count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b required 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL flush_fill: got %0d required 0", fill_count); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_out_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_matrix !== pack(p)) begin n_fail++; $display("FAIL flush_out_matrix: got %h required %h", out_matrix, pack(p)); end
        send_frame(q, 1'b1);
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_matrix !== pack(q)) begin n_fail++; $display("FAIL flush_next_matrix: got %h required %h", out_matrix, pack(q)); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_reset_in_hold();
        frame_t a, b;
        a = rand_frame();
        b = rand_frame();
        out_ready = 1'b0;
        send_frame(a, 1'b1);
        send_frame(b, 1'b1);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rhold_stalled: got %0b required 0", in_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rhold_ready_in_reset: got %0b required 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_out_valid: got %0b required 0", out_valid); end
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL rhold_fill: got %0d required 0", fill_count); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rhold_frame_err: got %0b required 0", frame_err); end
        n_checks++; if (out_matrix !== '0) begin n_fail++; $display("FAIL rhold_out_matrix: got %h required 0", out_matrix); end
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rhold_ready_after: got %0b required 1", in_ready); end
    endtask

    task automatic test_last_missing();
        frame_t d;
        d = rand_frame();
        out_ready = 1'b1;
        send_frame(d, 1'b0);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL nolast_frame_err: got %0b required 1", frame_err); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nolast_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_matrix !== pack(d)) begin n_fail++; $display("FAIL nolast_matrix: got %h required %h", out_matrix, pack(d)); end
        n_checks++; if (fill_count !== 5'd0) begin n_fail++; $display("FAIL nolast_fill: got %0d required 0", fill_count); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_hold_stall();
        test_no_bubble();
        test_continuous();
        test_frame_err();
        test_flush();
        test_reset_in_hold();
        test_last_missing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
